// File: rtl/gpio_pattern_seq.sv
// GPIO pattern sequencer on the 8-bit basil bus. It steps SEQ_OUT through a table of
// (pattern, dwell) entries. The whole table can repeat a fixed number of times or until stopped.
module gpio_pattern_seq #(
    parameter int unsigned BASEADDR  = 0,
    parameter int unsigned HIGHADDR  = 0,
    parameter int unsigned ABUSWIDTH = 16,
    parameter int unsigned IO_WIDTH  = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                 BUS_CLK,
    input  logic                 RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    inout  wire  [7:0]           BUS_DATA,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic                 EXT_START,
    output logic [IO_WIDTH-1:0]  SEQ_OUT,
    output logic                 SEQ_BUSY
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [7:0] VERSION = 8'd1;
    localparam logic [ABUSWIDTH-1:0] ADDR_VER   = ABUSWIDTH'(0);
    localparam logic [ABUSWIDTH-1:0] ADDR_CTRL  = ABUSWIDTH'(1);
    localparam logic [ABUSWIDTH-1:0] ADDR_LAST  = ABUSWIDTH'(2);
    localparam logic [ABUSWIDTH-1:0] ADDR_REP   = ABUSWIDTH'(3);
    localparam logic [ABUSWIDTH-1:0] ADDR_IDLE  = ABUSWIDTH'(4);
    localparam logic [ABUSWIDTH-1:0] MEM_BASE   = ABUSWIDTH'(16);
    localparam logic [ABUSWIDTH-1:0] MEM_SPAN   = ABUSWIDTH'(2 * DEPTH);
    localparam logic [ABUSWIDTH-1:0] IP_SPAN    = ABUSWIDTH'(HIGHADDR - BASEADDR);

    typedef enum logic {IDLE, RUN} state_t;

    // Local bus_to_ip: decode, relative address, registered read data driven for one cycle
    logic [ABUSWIDTH:0]   add_rel;
    logic [ABUSWIDTH-1:0] ip_add;
    logic [ABUSWIDTH-1:0] mem_rel;
    logic [AW-1:0]        mem_idx;
    logic [7:0]           wdata;
    logic cs, ip_rd, ip_wr, is_mem;
    logic soft_rst, ctrl_wr, start_wr, stop_wr, start_evt, pat_we, dwell_we;

    assign add_rel  = {1'b0, BUS_ADD} - (ABUSWIDTH+1)'(BASEADDR);
    assign ip_add   = add_rel[ABUSWIDTH-1:0];
    assign cs       = !add_rel[ABUSWIDTH] && (ip_add <= IP_SPAN);
    assign ip_rd    = cs && BUS_RD;
    assign ip_wr    = cs && BUS_WR;
    assign wdata    = BUS_DATA;
    assign mem_rel  = ip_add - MEM_BASE;
    assign is_mem   = (ip_add >= MEM_BASE) && (mem_rel < MEM_SPAN);
    assign mem_idx  = mem_rel[AW:1];
    assign pat_we   = ip_wr && is_mem && !mem_rel[0];
    assign dwell_we = ip_wr && is_mem && mem_rel[0];
    assign soft_rst = ip_wr && (ip_add == ADDR_VER);
    assign ctrl_wr  = ip_wr && (ip_add == ADDR_CTRL);
    assign start_wr = ctrl_wr && wdata[0];
    assign stop_wr  = ctrl_wr && wdata[2];

    logic [IO_WIDTH-1:0] pat_mem [DEPTH];
    logic [7:0]          dwell_mem [DEPTH];

    state_t              state_q, state_d;
    logic [AW-1:0]       step_q, step_d, run_last_q, run_last_d, last_step_q, last_step_d;
    logic [AW-1:0]       next_step;
    logic [7:0]          dwell_cnt_q, dwell_cnt_d, pass_cnt_q, pass_cnt_d, repeat_q, repeat_d;
    logic [IO_WIDTH-1:0] idle_val_q, idle_val_d, seq_out_q, seq_out_d;
    logic                run_inf_q, run_inf_d, done_q, done_d, start_pend_q, start_pend_d;
    logic                ext_en_q, ext_en_d, ext_prev_q;
    logic [7:0]          rd_data_q, rd_data_d;
    logic                rd_prev_q;
    logic                load_pat;

    assign next_step = step_q + AW'(1);
    assign start_evt = start_wr || (ext_en_q && EXT_START && !ext_prev_q);

    // Register writes, then the sequencer. A start is held one cycle in start_pend so the
    // first pattern appears one edge after the start is sampled.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        dwell_cnt_d  = dwell_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        run_last_d   = run_last_q;
        run_inf_d    = run_inf_q;
        done_d       = done_q;
        start_pend_d = 1'b0;
        ext_en_d     = ext_en_q;
        last_step_d  = last_step_q;
        repeat_d     = repeat_q;
        idle_val_d   = idle_val_q;
        load_pat     = 1'b0;

        if (ip_wr) begin
            case (ip_add)
                ADDR_CTRL: ext_en_d = wdata[1];
                ADDR_LAST: last_step_d = ({1'b0, wdata} >= 9'(DEPTH)) ? AW'(DEPTH - 1) : wdata[AW-1:0];
                ADDR_REP:  repeat_d = wdata;
                ADDR_IDLE: idle_val_d = wdata[IO_WIDTH-1:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (start_pend_q && !stop_wr) begin
                    state_d     = RUN;
                    step_d      = '0;
                    dwell_cnt_d = dwell_mem[0];
                    pass_cnt_d  = repeat_q;
                    run_last_d  = last_step_q;
                    run_inf_d   = (repeat_q == 8'hFF);
                    done_d      = 1'b0;
                    load_pat    = 1'b1;
                end else begin
                    start_pend_d = start_evt && !stop_wr;
                end
            end
            RUN: begin
                if (stop_wr) begin
                    state_d = IDLE;
                end else if (dwell_cnt_q != 8'd0) begin
                    dwell_cnt_d = dwell_cnt_q - 8'd1;
                end else if (step_q != run_last_q) begin
                    step_d      = next_step;
                    dwell_cnt_d = dwell_mem[next_step];
                    load_pat    = 1'b1;
                end else if (pass_cnt_q != 8'd0) begin
                    step_d      = '0;
                    dwell_cnt_d = dwell_mem[0];
                    load_pat    = 1'b1;
                    if (!run_inf_q) begin
                        pass_cnt_d = pass_cnt_q - 8'd1;
                    end
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (soft_rst) begin
            state_d      = IDLE;
            step_d       = '0;
            dwell_cnt_d  = '0;
            pass_cnt_d   = '0;
            run_last_d   = '0;
            run_inf_d    = 1'b0;
            done_d       = 1'b0;
            start_pend_d = 1'b0;
            ext_en_d     = 1'b0;
            last_step_d  = '0;
            repeat_d     = '0;
            idle_val_d   = '0;
        end

        // Pattern is latched only when a step is entered; later table writes do not disturb it
        if (state_d == IDLE) begin
            seq_out_d = idle_val_d;
        end else if (load_pat) begin
            seq_out_d = pat_mem[step_d];
        end else begin
            seq_out_d = seq_out_q;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (ip_rd) begin
            rd_data_d = 8'h00;
            if (ip_add == ADDR_VER) begin
                rd_data_d = VERSION;
            end else if (ip_add == ADDR_CTRL) begin
                rd_data_d = {done_q, 5'b00000, ext_en_q, state_q == RUN};
            end else if (ip_add == ADDR_LAST) begin
                rd_data_d = 8'(last_step_q);
            end else if (ip_add == ADDR_REP) begin
                rd_data_d = repeat_q;
            end else if (ip_add == ADDR_IDLE) begin
                rd_data_d = 8'(idle_val_q);
            end else if (is_mem) begin
                rd_data_d = mem_rel[0] ? dwell_mem[mem_idx] : 8'(pat_mem[mem_idx]);
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            step_q       <= '0;
            dwell_cnt_q  <= '0;
            pass_cnt_q   <= '0;
            run_last_q   <= '0;
            run_inf_q    <= 1'b0;
            done_q       <= 1'b0;
            start_pend_q <= 1'b0;
            ext_en_q     <= 1'b0;
            ext_prev_q   <= 1'b0;
            last_step_q  <= '0;
            repeat_q     <= '0;
            idle_val_q   <= '0;
            seq_out_q    <= '0;
            rd_data_q    <= '0;
            rd_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            dwell_cnt_q  <= dwell_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            run_last_q   <= run_last_d;
            run_inf_q    <= run_inf_d;
            done_q       <= done_d;
            start_pend_q <= start_pend_d;
            ext_en_q     <= ext_en_d;
            ext_prev_q   <= EXT_START;
            last_step_q  <= last_step_d;
            repeat_q     <= repeat_d;
            idle_val_q   <= idle_val_d;
            seq_out_q    <= seq_out_d;
            rd_data_q    <= rd_data_d;
            rd_prev_q    <= ip_rd;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (pat_we) begin
            pat_mem[mem_idx] <= wdata[IO_WIDTH-1:0];
        end
        if (dwell_we) begin
            dwell_mem[mem_idx] <= wdata;
        end
    end

    assign BUS_DATA = rd_prev_q ? rd_data_q : 8'hzz;
    assign SEQ_OUT  = seq_out_q;
    assign SEQ_BUSY = (state_q == RUN);

endmodule

// File: tb/tb_gpio_pattern_seq.sv
// Directed testbench for gpio_pattern_seq: bus register access, pattern timing, repeat,
// stop, external trigger, mid-run table writes and both reset paths.
module tb_gpio_pattern_seq;
    logic        BUS_CLK = 1'b0;
    logic        RST;
    logic [15:0] bus_add;
    wire  [7:0]  bus_data;
    logic        bus_rd, bus_wr, ext_start;
    logic [7:0]  seq_out;
    logic        seq_busy;
    logic        tb_drive;
    logic [7:0]  tb_wdata;

    int          errors = 0;
    int          checks = 0;
    int          busyCycles;
    logic [7:0]  trace[$];
    logic [7:0]  rd;
    logic [7:0]  passPat [6] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h04, 8'h04};

    assign bus_data = tb_drive ? tb_wdata : 8'hzz;

    always #5 BUS_CLK = ~BUS_CLK;

    gpio_pattern_seq #(
        .BASEADDR (0),
        .HIGHADDR (47),
        .ABUSWIDTH(16),
        .IO_WIDTH (8),
        .DEPTH    (16)
    ) dut (
        .BUS_CLK  (BUS_CLK),
        .RST      (RST),
        .BUS_ADD  (bus_add),
        .BUS_DATA (bus_data),
        .BUS_RD   (bus_rd),
        .BUS_WR   (bus_wr),
        .EXT_START(ext_start),
        .SEQ_OUT  (seq_out),
        .SEQ_BUSY (seq_busy)
    );

    // Every comparison in the bench goes through here
    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: wait for the falling edge and record outputs there
    task automatic tick();
        @(negedge BUS_CLK);
        trace.push_back(seq_out);
        if (seq_busy) busyCycles++;
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data);
        tick();
        bus_add  = addr;
        tb_wdata = data;
        tb_drive = 1'b1;
        bus_wr   = 1'b1;
        tick();
        bus_wr   = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [7:0] data);
        tick();
        bus_add = addr;
        bus_rd  = 1'b1;
        tick();
        data   = bus_data;
        bus_rd = 1'b0;
    endtask

    task automatic clearCounters();
        trace.delete();
        busyCycles = 0;
    endtask

    // Tick until the run has been seen busy and then idle; an expired budget is a failure
    task automatic waitIdle(input int maxCycles);
        bit seen = 1'b0;
        for (int n = 0; n < maxCycles; n++) begin
            tick();
            if (seq_busy) seen = 1'b1;
            else if (seen) return;
        end
        checkOutput("run_end_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST = 1'b1; bus_add = '0; bus_rd = 1'b0; bus_wr = 1'b0;
        ext_start = 1'b0; tb_drive = 1'b0; tb_wdata = '0; busyCycles = 0;
        repeat (3) tick();
        RST = 1'b0;
        tick();

        $display("[TB] reset state and idle value");
        checkOutput("rst_seq_out", seq_out, 8'h00);
        checkOutput("rst_busy", seq_busy, 0);
        busRead(16'd1, rd);
        checkOutput("rst_ctrl", rd, 8'h00);
        busRead(16'd0, rd);
        checkOutput("version", rd, 8'h01);
        applyStimulus(16'd4, 8'hA5);
        checkOutput("idle_val_out", seq_out, 8'hA5);

        $display("[TB] single pass");
        applyStimulus(16'd16, 8'h01); applyStimulus(16'd17, 8'd0);
        applyStimulus(16'd18, 8'h02); applyStimulus(16'd19, 8'd2);
        applyStimulus(16'd20, 8'h04); applyStimulus(16'd21, 8'd1);
        applyStimulus(16'd2, 8'd2);
        applyStimulus(16'd3, 8'd0);
        applyStimulus(16'd1, 8'h01);
        clearCounters();
        waitIdle(40);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("pass1_step%0d", i), trace[i], passPat[i]);
        checkOutput("pass1_end_idle", trace[6], 8'hA5);
        checkOutput("pass1_busy_len", busyCycles, 6);
        busRead(16'd1, rd);
        checkOutput("pass1_ctrl_done", rd, 8'h80);
        busRead(16'd18, rd);
        checkOutput("readback_pat1", rd, 8'h02);
        busRead(16'd19, rd);
        checkOutput("readback_dwell1", rd, 8'h02);

        $display("[TB] repeat 2");
        applyStimulus(16'd3, 8'd2);
        applyStimulus(16'd1, 8'h01);
        clearCounters();
        waitIdle(60);
        for (int i = 0; i < 18; i++) checkOutput($sformatf("rep2_cyc%0d", i), trace[i], passPat[i % 6]);
        checkOutput("rep2_end_idle", trace[18], 8'hA5);
        checkOutput("rep2_busy_len", busyCycles, 18);

        $display("[TB] endless repeat then stop");
        applyStimulus(16'd3, 8'hFF);
        applyStimulus(16'd1, 8'h01);
        clearCounters();
        repeat (40) tick();
        checkOutput("inf_busy_40", busyCycles, 40);
        applyStimulus(16'd1, 8'h04);
        checkOutput("stop_busy", seq_busy, 0);
        checkOutput("stop_seq_out", seq_out, 8'hA5);
        busRead(16'd1, rd);
        checkOutput("stop_ctrl_no_done", rd, 8'h00);

        $display("[TB] external trigger held high");
        applyStimulus(16'd3, 8'd0);
        applyStimulus(16'd1, 8'h02);
        clearCounters();
        ext_start = 1'b1;
        repeat (50) tick();
        ext_start = 1'b0;
        repeat (3) tick();
        checkOutput("ext_single_run", busyCycles, 6);
        busRead(16'd1, rd);
        checkOutput("ext_ctrl", rd, 8'h82);

        $display("[TB] start ignored during run");
        applyStimulus(16'd3, 8'd2);
        applyStimulus(16'd1, 8'h01);
        clearCounters();
        repeat (3) tick();
        applyStimulus(16'd1, 8'h01);
        waitIdle(60);
        checkOutput("restart_ignored_len", busyCycles, 18);

        $display("[TB] pattern write during run");
        applyStimulus(16'd3, 8'd0);
        applyStimulus(16'd1, 8'h01);
        clearCounters();
        applyStimulus(16'd20, 8'h80);
        waitIdle(40);
        checkOutput("midwr_step0", trace[0], 8'h01);
        checkOutput("midwr_step1", trace[1], 8'h02);
        checkOutput("midwr_step2a", trace[4], 8'h80);
        checkOutput("midwr_step2b", trace[5], 8'h80);
        checkOutput("midwr_end", trace[6], 8'hA5);
        busRead(16'd20, rd);
        checkOutput("midwr_readback", rd, 8'h80);
        applyStimulus(16'd20, 8'h04);

        $display("[TB] last step clamp");
        applyStimulus(16'd2, 8'd200);
        busRead(16'd2, rd);
        checkOutput("last_step_clamp", rd, 8'h0F);
        applyStimulus(16'd2, 8'd2);

        $display("[TB] hard reset mid-run");
        applyStimulus(16'd3, 8'hFF);
        applyStimulus(16'd1, 8'h01);
        repeat (5) tick();
        RST = 1'b1;
        tick();
        checkOutput("rst_mid_seq_out", seq_out, 8'h00);
        checkOutput("rst_mid_busy", seq_busy, 0);
        RST = 1'b0;
        busRead(16'd16, rd);
        checkOutput("rst_keep_pat0", rd, 8'h01);
        busRead(16'd20, rd);
        checkOutput("rst_keep_pat2", rd, 8'h04);
        busRead(16'd21, rd);
        checkOutput("rst_keep_dwell2", rd, 8'h01);
        busRead(16'd2, rd);
        checkOutput("rst_clr_last", rd, 8'h00);

        $display("[TB] soft reset mid-run");
        applyStimulus(16'd4, 8'hA5);
        applyStimulus(16'd2, 8'd2);
        applyStimulus(16'd3, 8'hFF);
        applyStimulus(16'd1, 8'h01);
        repeat (4) tick();
        applyStimulus(16'd0, 8'h00);
        checkOutput("srst_seq_out", seq_out, 8'h00);
        checkOutput("srst_busy", seq_busy, 0);
        busRead(16'd1, rd);
        checkOutput("srst_ctrl", rd, 8'h00);
        busRead(16'd3, rd);
        checkOutput("srst_clr_repeat", rd, 8'h00);
        busRead(16'd18, rd);
        checkOutput("srst_keep_pat1", rd, 8'h02);

        $display("[TB] stop and start together");
        applyStimulus(16'd4, 8'h3C);
        clearCounters();
        applyStimulus(16'd1, 8'h05);
        repeat (5) tick();
        checkOutput("stop_start_busy", busyCycles, 0);
        checkOutput("stop_start_out", seq_out, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gpio_pattern_seq.md
Name: gpio_pattern_seq

Overview:
- Bus-mapped sequencer that drives a GPIO output word through a programmed pattern of up to DEPTH steps.
- Each step has its own dwell time, and the whole pattern can repeat a programmable number of times.
- It sits on the standard 8-bit basil bus through bus_to_ip.
- SEQ_OUT feeds the output/enable path of GPIO pins, giving cycle-accurate toggling that host-driven register writes cannot achieve.

Parameters:
- BASEADDR, 0, first bus address of the block.
- HIGHADDR, 0, last bus address of the block.
- ABUSWIDTH, 16, bus address width.
- IO_WIDTH, 8, width of SEQ_OUT; legal range 1..8.
- DEPTH, 16, number of pattern steps; power of two, 2..128.

Ports:
- BUS_CLK  input  1  bus and sequencer clock.
- RST  input  1  reset, synchronous, active-high; clock BUS_CLK.
- BUS_ADD  input  ABUSWIDTH  bus address.
- BUS_DATA  inout  8  bus data.
- BUS_RD  input  1  bus read strobe.
- BUS_WR  input  1  bus write strobe.
- EXT_START  input  1  external trigger; synchronous to BUS_CLK; rising edge starts the sequence when enabled.
- SEQ_OUT  output  IO_WIDTH  sequenced output word.
- SEQ_BUSY  output  1  high while the sequence runs.

Behaviour:

Register map (offsets from BASEADDR):
- 0: write = soft reset. Read = VERSION = 1.
- 1 CTRL, write: bit0 START (self-clearing pulse), bit1 EXT_EN, bit2 STOP (self-clearing pulse).
- 1 CTRL, read: bit0 BUSY, bit1 EXT_EN, bit7 DONE.
- 2 LAST_STEP: index of the final step. A written value >= DEPTH is stored as DEPTH-1.
- 3 REPEAT: number of extra passes. 0 = one pass; 0xFF = run until STOP.
- 4 IDLE_VAL: value driven on SEQ_OUT when not running; bits above IO_WIDTH are ignored.
- 16+2k: PAT[k] (bits [IO_WIDTH-1:0]). 17+2k: DWELL[k], step held DWELL[k]+1 cycles. k = 0..DEPTH-1.
- All other addresses read 0; writes to them are ignored.

Bus reads:
- Registered, one cycle latency, per bus_to_ip.
- Pattern memory is readable back at any time.

Reset:
- RST or soft reset clears CTRL, LAST_STEP, REPEAT, IDLE_VAL, DONE, state, step index, dwell counter and pass counter.
- After reset: SEQ_OUT = 0, SEQ_BUSY = 0.
- Pattern memory is not cleared.
- Reset mid-run aborts immediately, returning to IDLE on the same edge.

States: IDLE, RUN.

IDLE:
- SEQ_OUT = IDLE_VAL, SEQ_BUSY = 0.
- A start event moves to RUN. Start event = START written, or EXT_EN=1 and an EXT_START rising edge (EXT_START 0 in the previous cycle, 1 now).
- Let t be the edge where the start event is sampled. At edge t+1: SEQ_OUT = PAT[0], BUSY = 1, DONE cleared, dwell counter = DWELL[0], pass counter = REPEAT.

RUN:
- Each cycle, dwell counter > 0 → decrement.
- Dwell counter = 0 and step < LAST_STEP → advance step and load PAT/DWELL of the new step on that edge.
- Dwell counter = 0 at LAST_STEP:
  - pass counter > 0 → wrap to step 0. Decrement pass counter unless REPEAT = 0xFF.
  - pass counter = 0 → IDLE on the next edge, SEQ_OUT = IDLE_VAL, DONE = 1 (sticky until next start or reset).
- Step-to-step transitions have no gap cycles.
- Total run length = (sum of (DWELL[k]+1) for k=0..LAST_STEP) x (REPEAT+1) cycles.

Boundary and simultaneous-event rules:
- PAT/DWELL are sampled at the edge a step is entered. Memory writes during RUN affect only steps entered later.
- LAST_STEP and REPEAT are sampled at start. Writes to them during RUN take effect at the next start.
- IDLE_VAL writes are visible on SEQ_OUT next edge when IDLE.
- Start events in RUN are ignored; no queueing.
- STOP in RUN → IDLE next edge, DONE not set. STOP in IDLE → no effect.
- STOP and START written together (bits 0 and 2 both set) → STOP wins; the block ends in IDLE.
- Soft reset has priority over every other write.
- EXT_START held high generates only one start event.

Test Plan:
- Reset; read CTRL → 0x00; SEQ_OUT = 0; write IDLE_VAL = 0xA5 → SEQ_OUT = 0xA5 on the next cycle.
- PAT = {0x01, 0x02, 0x04}, DWELL = {0, 2, 1}, LAST_STEP = 2, REPEAT = 0, START → SEQ_OUT reads 01, 02, 02, 02, 04, 04, then IDLE_VAL. BUSY is high exactly 6 cycles; CTRL read afterwards = 0x80.
- Same pattern with REPEAT = 2 → 18 busy cycles, with 0x04 followed directly by 0x01 at each wrap. With REPEAT = 0xFF and STOP written after 40 cycles → IDLE next edge, DONE = 0.
- EXT_EN = 1, EXT_START held high for 50 cycles → exactly one run. A second START written mid-run → ignored; run length unchanged.
- During RUN, write PAT[2] = 0x80 while step 0 is active → step 2 outputs 0x80. Write LAST_STEP = 200 → reads back DEPTH-1.
- RST asserted mid-run → SEQ_OUT = 0, BUSY = 0 next edge; pattern memory readback unchanged. Soft reset write at offset 0 → same result.
